switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of router ports (0=local NI, 1=north, 2=south, 3=east, 4=west).
REQ-002 Parameter CREDITS, default 4, downstream buffer depth per output port (matches router input FIFO depth).
REQ-003 Parameter CNT_W, default $clog2(CREDITS+1), credit counter width.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset: one clock, synchronous to i_clk, active-high.
REQ-006 i_req  input  NUM_PORTS x NUM_PORTS  i_req[i] one-hot output requested by input FIFO i's head packet; all-zero means no request.
REQ-007 o_grant  output  NUM_PORTS x NUM_PORTS  o_grant[o] one-hot input granted output o this cycle; all-zero means idle.
REQ-008 o_pop  output  NUM_PORTS  o_pop[i] high when input i wins any output this cycle (FIFO dequeue strobe).
REQ-009 i_creditReturn  input  NUM_PORTS  pulse: downstream of output o freed one slot.
REQ-010 o_credit  output  NUM_PORTS x CNT_W  current credit count per output.
REQ-011 o_err  output  2  sticky: bit0 credit overflow, bit1 malformed (multi-hot) request.

Function
REQ-012 Grants are combinational from i_req, credits and round-robin pointers (zero-cycle latency); pointers, credits and errors are registered.
REQ-013 Output o is eligible only when o_credit[o] > 0; an ineligible output grants nothing.
REQ-014 Among inputs requesting an eligible output o, the grant goes to the first requester at or after ptr[o], searching upward modulo NUM_PORTS.
REQ-015 After a grant to input i on output o, ptr[o] becomes (i+1) mod NUM_PORTS at the next edge; with no grant, ptr[o] is unchanged.
REQ-016 o_pop[i] is the OR over o of o_grant[o][i]; XY routing makes each input request at most one output, so no input-side conflict exists.
REQ-017 A multi-hot i_req[i] is treated as no request from input i and sets o_err[1].
REQ-018 Credit update per output: grant only gives -1; return only gives +1; grant and return in the same cycle leave the count unchanged.
REQ-019 A return while the count equals CREDITS (with no grant that cycle) leaves the count at CREDITS and sets o_err[0].
REQ-020 A grant never drives a count below 0 (guaranteed by REQ-013).
REQ-021 An output at 0 credits with a same-cycle return grants nothing that cycle; it becomes eligible on the next cycle.
REQ-022 U-turns (input i requesting output i) are legal and are arbitrated normally.
REQ-023 Errors clear only on reset.

Reset
REQ-024 While i_rst is high: o_grant and o_pop are forced to 0 combinationally, and i_req and i_creditReturn are ignored.
REQ-025 At the edge with i_rst high: every ptr is set to 0, every o_credit to CREDITS, and o_err to 0.
REQ-026 Reset asserted mid-traffic discards all in-flight credit accounting, with no partial update on that edge.

Structure
REQ-027 Package pa_noc holds NUM_PORTS, the port-index enumeration (LOCAL, NORTH, SOUTH, EAST, WEST) and the default FIFO depth used for CREDITS.
REQ-028 The design uses one sub-module, rr_arbiter (NUM_PORTS-wide request vector, pointer state, one-hot grant, advance-on-grant), instantiated once per output.
REQ-029 The design targets 150-300 RTL lines, with no multi-cycle paths and no latches.

Verification
REQ-030 After reset, all inputs request output 3 for 6 cycles with no returns -> grants go to inputs 0,1,2,3 (one per cycle), then none; o_credit[3] reads 4,3,2,1,0,0.
REQ-031 o_credit[1]=0, a return pulse on output 1 and a request from input 2 in the same cycle -> no grant that cycle, o_credit[1]=1; grant to input 2 on the next cycle.
REQ-032 Continuous grants and returns on output 4 for 10 cycles, starting at o_credit[4]=2 -> o_credit[4] stays 2 throughout and o_err stays 0.
REQ-033 Inputs 0 and 4 both request output 0 persistently with returns keeping credits topped up -> grants alternate 0,4,0,4; pointer wrap from 4 back to 0 is verified.
REQ-034 Return pulse on output 2 while o_credit[2]=4 -> count stays 4 and o_err[0] goes to 1 and holds until reset.
REQ-035 i_req[1]=5'b01010 -> no grant and o_pop[1]=0, o_err[1] sets; i_rst mid-burst -> next cycle o_credit all 4, ptr all 0, o_err 0.

Source files
------------

// File: rtl/pa_noc.sv
// Shared NoC constants: router port count, port indices and the default
// per-port input FIFO depth that sets the downstream credit budget.
package pa_noc;

  localparam int NUM_PORTS  = 5;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output: first requester at or after the
// pointer wins; the pointer moves just past the winner on every grant.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          any_grant;
  int            idx_sum;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    idx       = '0;
    idx_sum   = 0;
    for (int k = 0; k < N; k++) begin
      idx_sum = int'(ptr_q) + k;
      if (idx_sum >= N) idx_sum = idx_sum - N;
      idx = PW'(idx_sum);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
        win_idx    = idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (any_grant) begin
      ptr_q <= (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: per-output round-robin arbitration gated by
// downstream credits, with credit accounting and sticky error flags.
module switch_allocator #(
  parameter int NUM_PORTS = pa_noc::NUM_PORTS,
  parameter int CREDITS   = pa_noc::FIFO_DEPTH,
  parameter int CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] o_grant,
  output logic [NUM_PORTS-1:0]                o_pop,
  input  logic [NUM_PORTS-1:0]                i_creditReturn,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]     o_credit,
  output logic [1:0]                          o_err
);

  import pa_noc::*;

  logic [NUM_PORTS-1:0]                req_ok;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] col_req;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant_w;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     credit_q;
  logic [NUM_PORTS-1:0][CNT_W-1:0]     credit_d;
  logic [1:0]                          err_q;
  logic                                malformed;
  logic                                overflow;

  // A multi-hot request vector is dropped entirely rather than guessed at.
  always_comb begin
    malformed = 1'b0;
    req_ok    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ok[i] = $onehot(i_req[i]);
      if ((i_req[i] != '0) && !req_ok[i]) malformed = 1'b1;
    end
  end

  // Transpose input-major requests into per-output columns, masked by credit and reset.
  always_comb begin
    col_req = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        col_req[o][i] = !i_rst && req_ok[i] && i_req[i][o] && (credit_q[o] != '0);
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .req   (col_req[o]),
      .grant (grant_w[o])
    );
  end

  always_comb begin
    o_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) o_pop = o_pop | grant_w[o];
  end

  // Grant and return in one cycle cancel; a return at full count is an overflow.
  always_comb begin
    overflow = 1'b0;
    credit_d = credit_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      case ({|grant_w[o], i_creditReturn[o]})
        2'b10: credit_d[o] = credit_q[o] - CNT_W'(1);
        2'b01: begin
          if (credit_q[o] == CNT_W'(CREDITS)) overflow = 1'b1;
          else credit_d[o] = credit_q[o] + CNT_W'(1);
        end
        default: credit_d[o] = credit_q[o];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int o = 0; o < NUM_PORTS; o++) credit_q[o] <= CNT_W'(CREDITS);
      err_q <= '0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_q | {malformed, overflow};
    end
  end

  assign o_grant  = grant_w;
  assign o_credit = credit_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus a
// randomized single-requester sweep against a small credit model.
module tb_switch_allocator;
  import pa_noc::*;

  localparam int NP = 5;
  localparam int CR = 4;
  localparam int CW = 3;

  logic                   clk;
  logic                   rst;
  logic [NP-1:0][NP-1:0]  req;
  logic [NP-1:0][NP-1:0]  grant;
  logic [NP-1:0]          pop;
  logic [NP-1:0]          ret;
  logic [NP-1:0][CW-1:0]  credit;
  logic [1:0]             err;

  int total = 0;
  int bad   = 0;
  logic [NP-1:0] exp_q[$];

  switch_allocator #(.NUM_PORTS(NP), .CREDITS(CR), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .o_grant        (grant),
    .o_pop          (pop),
    .i_creditReturn (ret),
    .o_credit       (credit),
    .o_err          (err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    req = '0;
    ret = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [NP-1:0][CW-1:0] full;
    for (int o = 0; o < NP; o++) full[o] = CW'(CR);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NP; i++) req[i] = NP'(1) << EAST;
    ret = '1;
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%0h exp=0", grant); end
    total++;
    if (pop !== '0) begin bad++; $display("FAIL reset_pop got=%0h exp=0", pop); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (credit !== full) begin bad++; $display("FAIL reset_credit got=%0h exp=%0h", credit, full); end
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
    next_cycle();
  endtask

  task automatic test_fill();
    logic [NP-1:0] e;
    logic [CW-1:0] ce;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NP; i++) req[i] = NP'(1) << EAST;
      exp_q.push_back((k < 4) ? (NP'(1) << k) : NP'(0));
      ce = (k < 4) ? CW'(4 - k) : CW'(0);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (grant[EAST] !== e) begin bad++; $display("FAIL fill_grant k=%0d got=%0h exp=%0h", k, grant[EAST], e); end
      total++;
      if (pop !== e) begin bad++; $display("FAIL fill_pop k=%0d got=%0h exp=%0h", k, pop, e); end
      total++;
      if (credit[EAST] !== ce) begin bad++; $display("FAIL fill_credit k=%0d got=%0d exp=%0d", k, credit[EAST], ce); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_zero_credit_return();
    logic [NP-1:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req[0] = NP'(1) << NORTH;
      next_cycle();
    end
    req[0] = '0;
    req[2] = NP'(1) << NORTH;
    ret[NORTH] = 1'b1;
    exp_q.push_back(NP'(0));
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (grant[NORTH] !== e) begin bad++; $display("FAIL zret_grant0 got=%0h exp=%0h", grant[NORTH], e); end
    total++;
    if (credit[NORTH] !== CW'(0)) begin bad++; $display("FAIL zret_credit0 got=%0d exp=0", credit[NORTH]); end
    next_cycle();
    ret = '0;
    exp_q.push_back(NP'(1) << 2);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (grant[NORTH] !== e) begin bad++; $display("FAIL zret_grant1 got=%0h exp=%0h", grant[NORTH], e); end
    total++;
    if (credit[NORTH] !== CW'(1)) begin bad++; $display("FAIL zret_credit1 got=%0d exp=1", credit[NORTH]); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_balanced();
    logic [NP-1:0] e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req[0] = NP'(1) << WEST;
      next_cycle();
    end
    req[0] = '0;
    for (int k = 0; k < 10; k++) begin
      req[1] = NP'(1) << WEST;
      ret[WEST] = 1'b1;
      exp_q.push_back(NP'(1) << 1);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (grant[WEST] !== e) begin bad++; $display("FAIL bal_grant k=%0d got=%0h exp=%0h", k, grant[WEST], e); end
      total++;
      if (credit[WEST] !== CW'(2)) begin bad++; $display("FAIL bal_credit k=%0d got=%0d exp=2", k, credit[WEST]); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (credit[WEST] !== CW'(2)) begin bad++; $display("FAIL bal_credit_end got=%0d exp=2", credit[WEST]); end
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL bal_err got=%0h exp=0", err); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [NP-1:0] e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req[0] = NP'(1) << LOCAL;
      req[4] = NP'(1) << LOCAL;
      ret[LOCAL] = 1'b1;
      exp_q.push_back((k % 2 == 0) ? (NP'(1) << 0) : (NP'(1) << 4));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (grant[LOCAL] !== e) begin bad++; $display("FAIL wrap_grant k=%0d got=%0h exp=%0h", k, grant[LOCAL], e); end
      total++;
      if (credit[LOCAL] !== CW'(CR)) begin bad++; $display("FAIL wrap_credit k=%0d got=%0d exp=4", k, credit[LOCAL]); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL wrap_err got=%0h exp=0", err); end
    next_cycle();
  endtask

  task automatic test_overflow();
    do_reset();
    ret[SOUTH] = 1'b1;
    @(negedge clk);
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL ovf_err_pre got=%0h exp=0", err); end
    next_cycle();
    ret = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (err !== 2'b01) begin bad++; $display("FAIL ovf_err k=%0d got=%0h exp=1", k, err); end
      total++;
      if (credit[SOUTH] !== CW'(CR)) begin bad++; $display("FAIL ovf_credit k=%0d got=%0d exp=4", k, credit[SOUTH]); end
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL ovf_err_clear got=%0h exp=0", err); end
    next_cycle();
  endtask

  task automatic test_malformed_midreset();
    logic [NP-1:0][CW-1:0] full;
    logic [NP-1:0] e;
    for (int o = 0; o < NP; o++) full[o] = CW'(CR);
    do_reset();
    req[1] = 5'b01010;
    req[3] = NP'(1) << SOUTH;
    @(negedge clk);
    total++;
    if (grant[NORTH] !== '0 || grant[EAST] !== '0) begin
      bad++; $display("FAIL mal_grant got=%0h/%0h exp=0/0", grant[NORTH], grant[EAST]);
    end
    total++;
    if (pop !== 5'b01000) begin bad++; $display("FAIL mal_pop got=%0h exp=08", pop); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if (err !== 2'b10) begin bad++; $display("FAIL mal_err got=%0h exp=2", err); end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) req[i] = NP'(1) << EAST;
      next_cycle();
    end
    rst = 1'b1;
    ret = '1;
    @(negedge clk);
    total++;
    if (grant !== '0 || pop !== '0) begin bad++; $display("FAIL midrst_grant got=%0h pop=%0h exp=0", grant, pop); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    req[0] = NP'(1) << EAST;
    req[2] = NP'(1) << EAST;
    exp_q.push_back(NP'(1) << 0);
    @(negedge clk);
    total++;
    if (credit !== full) begin bad++; $display("FAIL midrst_credit got=%0h exp=%0h", credit, full); end
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL midrst_err got=%0h exp=0", err); end
    e = exp_q.pop_front();
    total++;
    if (grant[EAST] !== e) begin bad++; $display("FAIL midrst_ptr got=%0h exp=%0h", grant[EAST], e); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random_single();
    int cred[NP];
    int i_sel;
    int o_sel;
    logic [NP-1:0] e;
    do_reset();
    for (int o = 0; o < NP; o++) cred[o] = CR;
    for (int k = 0; k < 16; k++) begin
      i_sel = $urandom_range(0, NP - 1);
      o_sel = $urandom_range(0, NP - 1);
      req = '0;
      req[i_sel] = NP'(1) << o_sel;
      exp_q.push_back((cred[o_sel] > 0) ? (NP'(1) << i_sel) : NP'(0));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (grant[o_sel] !== e) begin bad++; $display("FAIL rnd_grant k=%0d got=%0h exp=%0h", k, grant[o_sel], e); end
      total++;
      if (credit[o_sel] !== CW'(cred[o_sel])) begin
        bad++; $display("FAIL rnd_credit k=%0d got=%0d exp=%0d", k, credit[o_sel], cred[o_sel]);
      end
      if (cred[o_sel] > 0) cred[o_sel]--;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_zero_credit_return();
    test_balanced();
    test_wrap();
    test_overflow();
    test_malformed_midreset();
    test_random_single();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d exp=0", exp_q.size());
    end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
